// File: rtl/match_window_counter_if.sv
// Report channel of match_window_counter: registered report payload with valid/ready.
interface match_window_counter_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  modport master (
    output out_valid,
    output out_count,
    output out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_count,
    input  out_sat,
    output out_ready
  );

endinterface

// File: rtl/match_window_counter.sv
// Counts detector match pulses over fixed WIN_LEN-cycle windows and publishes one
// saturating report per window; reports dropped under backpressure are tallied.
module match_window_counter #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WIN_LEN = 64,
  parameter int unsigned WIN_W   = 16,
  parameter int unsigned LOST_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      z,
  match_window_counter_if.master    rpt,
  output logic [LOST_W-1:0]         lost_cnt,
  output logic                      win_active
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [LOST_W-1:0] LOST_MAX = '1;
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_LEN - 1);

  if (WIN_LEN < 2 || WIN_LEN > 65535 || (64'(WIN_LEN) - 64'd1) >= (64'd1 << WIN_W)) begin : g_bad_param
    $error("match_window_counter: WIN_LEN out of range or does not fit in WIN_W");
  end

  logic [0:0]        state_q,     state_d;
  logic [WIN_W-1:0]  wcnt_q,      wcnt_d;
  logic [CNT_W-1:0]  mcnt_q,      mcnt_d;
  logic              sat_acc_q,   sat_acc_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_sat_q,   out_sat_d;
  logic [LOST_W-1:0] lost_q,      lost_d;

  logic             mcnt_max_c;
  logic             close_c;
  logic [CNT_W-1:0] final_cnt_c;
  logic             final_sat_c;

  // Window-close qualification and the closing window's final count/flag, including this cycle's z.
  always_comb begin
    mcnt_max_c  = (mcnt_q == CNT_MAX);
    close_c     = (state_q == ST_RUN) && en && (wcnt_q == WIN_LAST);
    final_cnt_c = mcnt_q;
    final_sat_c = sat_acc_q;
    if (z) begin
      if (mcnt_max_c) begin
        final_sat_c = 1'b1;
      end else begin
        final_cnt_c = mcnt_q + 1'b1;
      end
    end
  end

  // Window sequencing: IDLE holds counters cleared, RUN steps the window index and counts matches.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mcnt_d    = mcnt_q;
    sat_acc_d = sat_acc_q;
    case (state_q)
      ST_IDLE: begin
        wcnt_d    = '0;
        mcnt_d    = '0;
        sat_acc_d = 1'b0;
        if (en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en || (wcnt_q == WIN_LAST)) begin
          // Abandon (en low) or close; a close rolls straight into the next window.
          wcnt_d    = '0;
          mcnt_d    = '0;
          sat_acc_d = 1'b0;
          if (!en) begin
            state_d = ST_IDLE;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          if (z) begin
            if (mcnt_max_c) begin
              sat_acc_d = 1'b1;
            end else begin
              mcnt_d = mcnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        wcnt_d    = '0;
        mcnt_d    = '0;
        sat_acc_d = 1'b0;
      end
    endcase
  end

  // Report register: a close loads it if the slot is free or being drained, otherwise the report is lost.
  always_comb begin
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    lost_d      = lost_q;
    if (close_c) begin
      if (!out_valid_q || rpt.out_ready) begin
        out_valid_d = 1'b1;
        out_count_d = final_cnt_c;
        out_sat_d   = final_sat_c;
      end else if (lost_q != LOST_MAX) begin
        lost_d = lost_q + 1'b1;
      end
    end else if (out_valid_q && rpt.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      mcnt_q      <= '0;
      sat_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      lost_q      <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mcnt_q      <= mcnt_d;
      sat_acc_q   <= sat_acc_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
      lost_q      <= lost_d;
    end
  end

  assign rpt.out_valid = out_valid_q;
  assign rpt.out_count = out_count_q;
  assign rpt.out_sat   = out_sat_q;
  assign lost_cnt      = lost_q;
  assign win_active    = (state_q == ST_RUN);

endmodule

// File: tb/tb_match_window_counter.sv
// Directed bench for match_window_counter (CNT_W=2, WIN_LEN=8, LOST_W=3) with a report scoreboard.
module tb_match_window_counter;

  localparam int unsigned CNT_W   = 2;
  localparam int unsigned WIN_LEN = 8;
  localparam int unsigned WIN_W   = 4;
  localparam int unsigned LOST_W  = 3;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic             sat;
  } rpt_t;

  logic              clk;
  logic              rst;
  logic              en;
  logic              z;
  logic [LOST_W-1:0] lost_cnt;
  logic              win_active;

  int   n_checks;
  int   n_err;
  rpt_t exp_q[$];
  rpt_t held;

  match_window_counter_if #(.CNT_W(CNT_W)) rpt_if ();

  match_window_counter #(
    .CNT_W  (CNT_W),
    .WIN_LEN(WIN_LEN),
    .WIN_W  (WIN_W),
    .LOST_W (LOST_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .z         (z),
    .rpt       (rpt_if),
    .lost_cnt  (lost_cnt),
    .win_active(win_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive window indices lo..hi with per-index z and out_ready taken from the masks.
  task automatic run_window(input logic [7:0] zm, input logic [7:0] rm, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      z               = zm[i];
      rpt_if.out_ready = rm[i];
      tick();
    end
    z = 1'b0;
  endtask

  task automatic push_exp(input logic [CNT_W-1:0] c, input logic s);
    rpt_t r;
    r.count = c;
    r.sat   = s;
    exp_q.push_back(r);
  endtask

  task automatic check_report(input string tag);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL %s observed=report expected=none_queued", tag);
    end else begin
      held = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(rpt_if.out_valid), 32'd1);
      chk({tag, "_count"}, 32'(rpt_if.out_count), 32'(held.count));
      chk({tag, "_sat"},   32'(rpt_if.out_sat),   32'(held.sat));
    end
  endtask

  task automatic check_held(input string tag, input int exp_lost);
    chk({tag, "_valid"}, 32'(rpt_if.out_valid), 32'd1);
    chk({tag, "_count"}, 32'(rpt_if.out_count), 32'(held.count));
    chk({tag, "_sat"},   32'(rpt_if.out_sat),   32'(held.sat));
    chk({tag, "_lost"},  32'(lost_cnt),         32'(exp_lost));
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    held     = '0;
    rst = 1'b1; en = 1'b0; z = 1'b0; rpt_if.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid",  32'(rpt_if.out_valid), 32'd0);
    chk("rst_count",  32'(rpt_if.out_count), 32'd0);
    chk("rst_sat",    32'(rpt_if.out_sat),   32'd0);
    chk("rst_lost",   32'(lost_cnt),         32'd0);
    chk("rst_active", 32'(win_active),       32'd0);

    // IDLE -> RUN; window index 0 follows.
    rst = 1'b0; en = 1'b1; rpt_if.out_ready = 1'b1;
    tick();
    chk("run_active", 32'(win_active), 32'd1);

    // Matches at indices 1,4,7.
    push_exp(2'd3, 1'b0);
    run_window(8'b1001_0010, 8'hFF, 0, 7);
    check_report("w1");

    // Back-to-back window, z every cycle saturates a 2-bit count.
    push_exp(2'd3, 1'b1);
    run_window(8'hFF, 8'hFF, 0, 7);
    check_report("w2_sat");

    push_exp(2'd0, 1'b0);
    run_window(8'h00, 8'hFF, 0, 7);
    check_report("w3_zero");

    // Backpressure: first report held, next two lost.
    push_exp(2'd1, 1'b0);
    run_window(8'h04, 8'h01, 0, 7);
    check_report("w4");
    run_window(8'h01, 8'h00, 0, 7);
    check_held("w5_held", 1);
    run_window(8'h01, 8'h00, 0, 7);
    check_held("w6_held", 2);

    // One cycle of ready drains the held report.
    run_window(8'h00, 8'h01, 0, 0);
    chk("drain_valid", 32'(rpt_if.out_valid), 32'd0);
    push_exp(2'd1, 1'b0);
    run_window(8'h08, 8'h00, 1, 7);
    check_report("w7");

    // Accept and close in the same cycle: new report loads, nothing lost.
    push_exp(2'd2, 1'b0);
    run_window(8'h06, 8'h80, 0, 7);
    check_report("w8_acc_close");
    chk("w8_lost", 32'(lost_cnt), 32'd2);

    // en dropped at index 5 after two matches.
    run_window(8'h03, 8'hFF, 0, 4);
    en = 1'b0;
    rpt_if.out_ready = 1'b1;
    tick();
    chk("abandon_active", 32'(win_active),       32'd0);
    chk("abandon_valid",  32'(rpt_if.out_valid), 32'd0);
    chk("abandon_lost",   32'(lost_cnt),         32'd2);
    en = 1'b1;
    tick();
    push_exp(2'd1, 1'b0);
    run_window(8'h10, 8'h00, 0, 7);
    check_report("w10_restart");

    run_window(8'h00, 8'h00, 0, 7);
    run_window(8'h00, 8'h00, 0, 7);
    check_held("w12_held", 4);

    // Reset mid-window with a pending report and lost_cnt=4.
    run_window(8'h00, 8'h00, 0, 2);
    rst = 1'b1;
    tick();
    chk("midrst_valid",  32'(rpt_if.out_valid), 32'd0);
    chk("midrst_count",  32'(rpt_if.out_count), 32'd0);
    chk("midrst_sat",    32'(rpt_if.out_sat),   32'd0);
    chk("midrst_lost",   32'(lost_cnt),         32'd0);
    chk("midrst_active", 32'(win_active),       32'd0);
    if (exp_q.size() != 0) exp_q.delete();

    // lost_cnt saturation: one loaded report then eight lost windows.
    rst = 1'b0; en = 1'b1; rpt_if.out_ready = 1'b0;
    tick();
    push_exp(2'd1, 1'b0);
    run_window(8'h20, 8'h00, 0, 7);
    check_report("w14");
    for (int w = 0; w < 8; w++) begin
      run_window(8'h01, 8'h00, 0, 7);
    end
    check_held("lost_sat", 7);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/match_window_counter.md
Name: match_window_counter

Overview:
- Downstream consumer of the serial 1011 Moore detector's one-cycle match output z.
- Counts detector matches over fixed windows of WIN_LEN clock cycles.
- Publishes one report per window, holding a saturating count and a saturation flag, over a valid/ready handshake.
- Tracks reports lost to backpressure so software/bench can see dropped windows.

Parameters:
- CNT_W, 8, width of per-window match count (saturating).
- WIN_LEN, 64, window length in clk cycles; legal range 2..65535.
- WIN_W, 16, width of window cycle counter; must hold WIN_LEN-1.
- LOST_W, 8, width of lost-report counter (saturating).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  run enable; windows run only while high.
- z  input  1  match pulse from detector; each high cycle = one match.
- out_valid  output  1  report register holds an unaccepted report.
- out_ready  input  1  consumer accepts report when out_valid && out_ready.
- out_count  output  CNT_W  match count of reported window.
- out_sat  output  1  count saturated during reported window.
- lost_cnt  output  LOST_W  number of window reports discarded; saturates.
- win_active  output  1  high while state==RUN.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, wcnt=0, mcnt=0, sat_acc=0, out_valid=0, out_count=0, out_sat=0, lost_cnt=0. Applies mid-window and with a pending report; pending report is discarded, not counted as lost.
- States: IDLE, RUN.
  - IDLE: wcnt/mcnt/sat_acc held at 0; z ignored. en=1 -> RUN next edge.
  - RUN: z sampled every cycle; wcnt = window cycle index 0..WIN_LEN-1. The first RUN cycle is index 0.
- Counting: on z=1, mcnt<=mcnt+1 unless mcnt==2^CNT_W-1. If it is at max, mcnt holds and sat_acc<=1. No wrap ever.
- Window close: a cycle in RUN with wcnt==WIN_LEN-1 and en=1.
  - Final value = mcnt+z, saturated; flag = sat_acc OR (z AND mcnt at max).
  - At that edge: wcnt, mcnt and sat_acc go to 0.
  - State stays RUN; the next window starts with no gap cycle.
- en=0 in RUN, any wcnt including the last: window abandoned, no report, no lost_cnt change. Counters cleared, state goes to IDLE next edge.
- Report load at close:
  - If out_valid=0, or out_valid=1 with out_ready=1 the same cycle: out_count/out_sat load the final values, out_valid=1 next cycle. Latency is 1 cycle after the last window cycle.
  - If out_valid=1 and out_ready=0: the new report is discarded, and the held report is unchanged. lost_cnt<=lost_cnt+1, saturating at 2^LOST_W-1.
- Handshake:
  - out_valid && out_ready with no close that cycle -> out_valid=0 next edge.
  - out_count/out_sat stay stable while out_valid=1 and not accepted.
  - out_ready is ignored while out_valid=0.
- Outputs are registered; no combinational path from z or out_ready to any output.
- lost_cnt is cleared only by rst.

Test Plan:
- WIN_LEN=8, en=1 held, out_ready=1, z=1 at window indices 1,4,7 -> the cycle after index 7 shows out_valid=1, out_count=3, out_sat=0. The next window counts from 0 immediately.
- CNT_W=2, WIN_LEN=8, z=1 all 8 cycles -> out_count=3, out_sat=1. The following window with z=0 throughout -> out_count=0, out_sat=0.
- WIN_LEN=8, out_ready=0 for 3 windows, z once per window -> first report (count=1) is held throughout, and lost_cnt=2. Then out_ready=1 for one cycle -> out_valid=0 next cycle.
- out_valid=1 and out_ready=1 in the same cycle as a window close with 2 matches -> out_valid stays 1, out_count=2, lost_cnt unchanged.
- en dropped at window index 5 after 2 matches -> no report, win_active=0 next cycle. en raised again with 1 match in a full window -> out_count=1, not 3.
- rst asserted at window index 3 with out_valid=1 and lost_cnt=4 -> next cycle shows out_valid=0, out_count=0, lost_cnt=0, win_active=0.
